// File: rtl/memory_writeback_if.sv
// Data-memory bus between the memory/writeback stage and the data memory.
//   master : stage side  - drives mem_req/mem_wr/mem_addr/mem_be/mem_wdata,
//                          receives mem_ack/mem_rdata
//   slave  : memory side - the reverse
interface memory_writeback_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_writeback.sv
// Combined memory-access / writeback stage of the shrv32 core.
// Accepts one instruction result at a time, performs a data-memory load or
// store over a req/ack handshake, aligns and extends load data, and drives
// the register-file write port for one cycle.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               issue pulse, accepted only while busy_o is low
//   op_i                  00 ALU, 01 load, 10 store, 11 jump-link
//   funct3_i              access size/sign (undefined codes act as word)
//   rd_i                  destination register
//   alu_y_i               ALU result or effective address
//   pc_i                  instruction PC (jump-link writes pc_i + 4)
//   store_data_i          store data (rs2)
//   busy_o                instruction in flight
//   wb_o, a3_o, we_o      register-file write port
//   err_o                 misalign/timeout flag, sticky until next accepted start
//   mem                   data-memory bus (master side)
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_ack.
module memory_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_y_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic [31:0] wb_o,
  output logic [4:0]  a3_o,
  output logic        we_o,
  output logic        err_o,
  memory_writeback_if.master mem
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite} state_e;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  localparam logic [1:0] OpAlu   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  function automatic logic [1:0] size_of(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      3'b000, 3'b100: sz = SzByte;
      3'b001, 3'b101: sz = SzHalf;
      default:        sz = SzWord;
    endcase
    return sz;
  endfunction

  state_e state_q, state_d;

  logic        busy_q, busy_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  a3_q, a3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  alo_q, alo_d;     // byte offset of the access, for load lane select
  logic [2:0]  funct3_q, funct3_d;

  logic        accept;
  logic        is_mem;
  logic [1:0]  start_sz;
  logic        misalign;
  logic        timeout;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign accept   = start_i && (state_q == StIdle);
  assign is_mem   = (op_i == OpLoad) || (op_i == OpStore);
  assign start_sz = size_of(funct3_i);
  assign misalign = ((start_sz == SzHalf) && alu_y_i[0]) ||
                    ((start_sz == SzWord) && (alu_y_i[1:0] != 2'b00));

  // Load alignment: shift the addressed lane down to bit 0, then extend.
  assign lane = mem.mem_rdata >> {alo_q, 3'b000};

  always_comb begin
    load_val = lane;
    case (size_of(funct3_q))
      SzByte:  load_val = {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
      SzHalf:  load_val = {{16{~funct3_q[2] & lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : CntRaw;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts ACCESS cycles without ack; cleared in every other state.
  assign cnt_d   = ((state_q == StAccess) && !mem.mem_ack) ? cnt_q + CntW'(1) : '0;
  assign timeout = (state_q == StAccess) && !mem.mem_ack &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_mem)       state_d = StWrite;
          else if (misalign) state_d = StIdle;
          else               state_d = StAccess;
        end
      end
      StAccess: begin
        if (mem.mem_ack)  state_d = wr_q ? StIdle : StWrite;
        else if (timeout) state_d = StIdle;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    busy_d   = busy_q;
    wb_d     = wb_q;
    a3_d     = a3_q;
    we_d     = 1'b0;
    err_d    = err_q;
    req_d    = req_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    alo_d    = alo_q;
    funct3_d = funct3_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          busy_d   = 1'b1;
          err_d    = 1'b0;
          a3_d     = rd_i;
          alo_d    = alu_y_i[1:0];
          funct3_d = funct3_i;
          if (!is_mem) begin
            wb_d = (op_i == OpAlu) ? alu_y_i : pc_i + 32'd4;
            we_d = (rd_i != 5'd0);
          end else if (misalign) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            req_d  = 1'b1;
            wr_d   = (op_i == OpStore);
            addr_d = {alu_y_i[31:2], 2'b00};
            case (start_sz)
              SzByte: begin
                be_d    = 4'b0001 << alu_y_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
              end
              SzHalf: begin
                be_d    = 4'b0011 << alu_y_i[1:0];
                wdata_d = {2{store_data_i[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_i;
              end
            endcase
          end
        end
      end
      StAccess: begin
        if (mem.mem_ack) begin
          req_d = 1'b0;
          if (wr_q) begin
            busy_d = 1'b0;
          end else begin
            wb_d = load_val;
            we_d = (a3_q != 5'd0);
          end
        end else if (timeout) begin
          req_d  = 1'b0;
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      StWrite: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      wb_q     <= '0;
      a3_q     <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      alo_q    <= '0;
      funct3_q <= '0;
    end else begin
      busy_q   <= busy_d;
      wb_q     <= wb_d;
      a3_q     <= a3_d;
      we_q     <= we_d;
      err_q    <= err_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      alo_q    <= alo_d;
      funct3_q <= funct3_d;
    end
  end

  assign busy_o        = busy_q;
  assign wb_o          = wb_q;
  assign a3_o          = a3_q;
  assign we_o          = we_q;
  assign err_o         = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_wr    = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_writeback.sv
module tb_memory_writeback;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TbTimeout = 4;
`else
  localparam int unsigned TbTimeout = 255;
`endif

  localparam int KAlu = 0, KLoad = 1, KStore = 2, KMis = 3;

  typedef struct {
    int          kind;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] sd;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] exp_wb;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_y, pc, store_data;
  logic        busy, we, err;
  logic [31:0] wb;
  logic [4:0]  a3;

  int total, bad;
  vec_t vecs[16];

  memory_writeback_if mem_bus ();

  memory_writeback #(
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .op_i         (op),
    .funct3_i     (funct3),
    .rd_i         (rd),
    .alu_y_i      (alu_y),
    .pc_i         (pc),
    .store_data_i (store_data),
    .busy_o       (busy),
    .wb_o         (wb),
    .a3_o         (a3),
    .we_o         (we),
    .err_o        (err),
    .mem          (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int kind, logic [1:0] o, logic [2:0] f3, logic [4:0] r,
                              logic [31:0] a, logic [31:0] p, logic [31:0] s, int d,
                              logic [31:0] rdat, logic [31:0] ewb, logic ewe,
                              logic [31:0] eaddr, logic [3:0] ebe, logic [31:0] ewd);
    vec_t v;
    v.kind = kind; v.op = o; v.f3 = f3; v.rd = r; v.alu = a; v.pc = p; v.sd = s;
    v.dly = d; v.rdata = rdat; v.exp_wb = ewb; v.exp_we = ewe; v.exp_addr = eaddr;
    v.exp_be = ebe; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] p, input logic [31:0] s);
    start = 1'b1; op = o; funct3 = f3; rd = r; alu_y = a; pc = p; store_data = s;
  endtask

  // Starts at a negedge; start is sampled at the following posedge (edge 0).
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    issue(v.op, v.f3, v.rd, v.alu, v.pc, v.sd);
    @(negedge clk);
    start = 1'b0;
    case (v.kind)
      KAlu: begin
        check({t, ".we"}, 32'(we), 32'(v.exp_we));
        check({t, ".wb"}, wb, v.exp_wb);
        if (v.exp_we) check({t, ".a3"}, 32'(a3), 32'(v.rd));
        check({t, ".busy1"}, 32'(busy), 32'd1);
        check({t, ".err"}, 32'(err), 32'd0);
        @(negedge clk);
        check({t, ".we2"}, 32'(we), 32'd0);
        check({t, ".busy2"}, 32'(busy), 32'd0);
      end
      KMis: begin
        check({t, ".err"}, 32'(err), 32'd1);
        check({t, ".busy"}, 32'(busy), 32'd0);
        check({t, ".req"}, 32'(mem_bus.mem_req), 32'd0);
        check({t, ".we"}, 32'(we), 32'd0);
        @(negedge clk);
        check({t, ".req2"}, 32'(mem_bus.mem_req), 32'd0);
        check({t, ".err2"}, 32'(err), 32'd1);
      end
      default: begin
        check({t, ".req"}, 32'(mem_bus.mem_req), 32'd1);
        check({t, ".addr"}, mem_bus.mem_addr, v.exp_addr);
        check({t, ".be"}, 32'(mem_bus.mem_be), 32'(v.exp_be));
        check({t, ".wr"}, 32'(mem_bus.mem_wr), 32'(v.kind == KStore));
        check({t, ".err"}, 32'(err), 32'd0);
        if (v.kind == KStore) check({t, ".wdata"}, mem_bus.mem_wdata, v.exp_wdata);
        for (int i = 1; i < v.dly; i++) @(negedge clk);
        check({t, ".reqhold"}, 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = v.rdata;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        check({t, ".reqdrop"}, 32'(mem_bus.mem_req), 32'd0);
        if (v.kind == KLoad) begin
          check({t, ".we"}, 32'(we), 32'(v.exp_we));
          check({t, ".wb"}, wb, v.exp_wb);
          check({t, ".a3"}, 32'(a3), 32'(v.rd));
          @(negedge clk);
          check({t, ".we2"}, 32'(we), 32'd0);
          check({t, ".busy2"}, 32'(busy), 32'd0);
        end else begin
          check({t, ".we"}, 32'(we), 32'd0);
          check({t, ".busy"}, 32'(busy), 32'd0);
        end
      end
    endcase
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; op = '0; funct3 = '0; rd = '0;
    alu_y = '0; pc = '0; store_data = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    //            kind    op     f3      rd     alu            pc            sd
    //            dly rdata          exp_wb         we    addr           be       wdata
    vecs[0]  = mk(KAlu,   2'b00, 3'b000, 5'd5,  32'h12345678, 32'h0,        32'h0,
                  0, 32'h0,          32'h12345678, 1'b1, 32'h0,        4'h0,    32'h0);
    vecs[1]  = mk(KAlu,   2'b11, 3'b000, 5'd1,  32'h0,        32'h00001000, 32'h0,
                  0, 32'h0,          32'h00001004, 1'b1, 32'h0,        4'h0,    32'h0);
    vecs[2]  = mk(KAlu,   2'b11, 3'b000, 5'd0,  32'h0,        32'hFFFFFFFC, 32'h0,
                  0, 32'h0,          32'h00000000, 1'b0, 32'h0,        4'h0,    32'h0);
    vecs[3]  = mk(KLoad,  2'b01, 3'b000, 5'd7,  32'h00000103, 32'h0,        32'h0,
                  3, 32'h80FFFFFF,   32'hFFFFFF80, 1'b1, 32'h00000100, 4'b1000, 32'h0);
    vecs[4]  = mk(KLoad,  2'b01, 3'b100, 5'd7,  32'h00000103, 32'h0,        32'h0,
                  3, 32'h80FFFFFF,   32'h00000080, 1'b1, 32'h00000100, 4'b1000, 32'h0);
    vecs[5]  = mk(KLoad,  2'b01, 3'b001, 5'd8,  32'h00000202, 32'h0,        32'h0,
                  1, 32'h80011234,   32'hFFFF8001, 1'b1, 32'h00000200, 4'b1100, 32'h0);
    vecs[6]  = mk(KLoad,  2'b01, 3'b101, 5'd9,  32'h00000200, 32'h0,        32'h0,
                  2, 32'h12349ABC,   32'h00009ABC, 1'b1, 32'h00000200, 4'b0011, 32'h0);
    vecs[7]  = mk(KLoad,  2'b01, 3'b010, 5'd31, 32'h00000300, 32'h0,        32'h0,
                  1, 32'hDEADBEEF,   32'hDEADBEEF, 1'b1, 32'h00000300, 4'b1111, 32'h0);
    vecs[8]  = mk(KLoad,  2'b01, 3'b000, 5'd3,  32'h00000101, 32'h0,        32'h0,
                  2, 32'h00004100,   32'h00000041, 1'b1, 32'h00000100, 4'b0010, 32'h0);
    vecs[9]  = mk(KStore, 2'b10, 3'b001, 5'd0,  32'h00000202, 32'h0,        32'hAAAABEEF,
                  2, 32'h0,          32'h0,        1'b0, 32'h00000200, 4'b1100, 32'hBEEFBEEF);
    vecs[10] = mk(KStore, 2'b10, 3'b000, 5'd4,  32'h00000401, 32'h0,        32'h12345678,
                  1, 32'h0,          32'h0,        1'b0, 32'h00000400, 4'b0010, 32'h78787878);
    vecs[11] = mk(KStore, 2'b10, 3'b010, 5'd4,  32'h00000500, 32'h0,        32'hCAFEF00D,
                  3, 32'h0,          32'h0,        1'b0, 32'h00000500, 4'b1111, 32'hCAFEF00D);
    vecs[12] = mk(KMis,   2'b01, 3'b010, 5'd6,  32'h00000101, 32'h0,        32'h0,
                  0, 32'h0,          32'h0,        1'b0, 32'h0,        4'h0,    32'h0);
    // ALU right after a misalign: ERR must clear on the new start
    vecs[13] = mk(KAlu,   2'b00, 3'b000, 5'd10, 32'h0000ABCD, 32'h0,        32'h0,
                  0, 32'h0,          32'h0000ABCD, 1'b1, 32'h0,        4'h0,    32'h0);
    vecs[14] = mk(KMis,   2'b10, 3'b001, 5'd6,  32'h00000203, 32'h0,        32'h0,
                  0, 32'h0,          32'h0,        1'b0, 32'h0,        4'h0,    32'h0);
    // undefined funct3 acts as word
    vecs[15] = mk(KLoad,  2'b01, 3'b011, 5'd12, 32'h00000104, 32'h0,        32'h0,
                  1, 32'h11223344,   32'h11223344, 1'b1, 32'h00000104, 4'b1111, 32'h0);

    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.we", 32'(we), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.req", 32'(mem_bus.mem_req), 32'd0);
    check("rst.wb", wb, 32'd0);
    check("rst.addr", mem_bus.mem_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // START while busy is ignored
    @(negedge clk);
    issue(2'b00, 3'b000, 5'd3, 32'h0000000A, 32'h0, 32'h0);
    @(negedge clk);
    check("busyign.we1", 32'(we), 32'd1);
    issue(2'b00, 3'b000, 5'd4, 32'h0000000B, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("busyign.we2", 32'(we), 32'd0);
    check("busyign.wb", wb, 32'h0000000A);
    check("busyign.a3", 32'(a3), 32'd3);
    @(negedge clk);
    check("busyign.we3", 32'(we), 32'd0);
    check("busyign.busy3", 32'(busy), 32'd0);

    // Back-to-back ALU ops at one per two cycles
    issue(2'b00, 3'b000, 5'd2, 32'h00000001, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("b2b.a3a", 32'(a3), 32'd2);
    @(negedge clk);
    check("b2b.busy", 32'(busy), 32'd0);
    issue(2'b00, 3'b000, 5'd6, 32'h00000002, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("b2b.we", 32'(we), 32'd1);
    check("b2b.a3b", 32'(a3), 32'd6);
    check("b2b.wb", wb, 32'h00000002);

    // MEM_ACK while idle is ignored
    @(negedge clk);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h77;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("ackidle.we", 32'(we), 32'd0);
    check("ackidle.busy", 32'(busy), 32'd0);
    check("ackidle.req", 32'(mem_bus.mem_req), 32'd0);

    // Reset during ACCESS aborts, late ack ignored
    @(negedge clk);
    issue(2'b01, 3'b010, 5'd9, 32'h00000600, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("rstacc.req1", 32'(mem_bus.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstacc.req", 32'(mem_bus.mem_req), 32'd0);
    check("rstacc.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h55;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("rstacc.lateack.we", 32'(we), 32'd0);
    check("rstacc.lateack.req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check("rstacc.lateack.we2", 32'(we), 32'd0);
    check("rstacc.lateack.wb", wb, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: request held four cycles, then abort with ERR
    @(negedge clk);
    issue(2'b01, 3'b010, 5'd11, 32'h00000700, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("tmo.req%0d", i), 32'(mem_bus.mem_req), 32'd1);
      @(negedge clk);
    end
    check("tmo.reqdrop", 32'(mem_bus.mem_req), 32'd0);
    check("tmo.err", 32'(err), 32'd1);
    check("tmo.we", 32'(we), 32'd0);
    check("tmo.busy", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_writeback.md
# memory_writeback

Combined memory-access and writeback stage of the shrv32 core, sitting directly upstream of the register file. It accepts one issued instruction result at a time, performs any data-memory load/store over a req/ack handshake, and aligns and sign-extends load data. It then drives the register file's write port (WB/A3/WE) for exactly one cycle. A small FSM sequences each instruction and flags misaligned or timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255: cycles MEM_REQ may wait for MEM_ACK before abort (used only with MEM_TIMEOUT_EN).
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  issue pulse; accepted only when BUSY=0.
- OP  in  2  00 ALU result, 01 load, 10 store, 11 jump-link (writes PC+4).
- FUNCT3  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- RD  in  5  destination register.
- ALU_Y  in  32  ALU result, or effective address for load/store.
- PC  in  32  instruction PC.
- STORE_DATA  in  32  rs2 value for stores.
- BUSY  out  1  high from accepted START until return to IDLE.
- MEM_REQ  out  1  memory request, held until ACK.
- MEM_WR  out  1  1 = store.
- MEM_ADDR  out  32  {ALU_Y[31:2], 2'b00}.
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  store data replicated into lanes.
- MEM_ACK  in  1  completion; read data valid same cycle.
- MEM_RDATA  in  32  read word.
- WB  out  32  writeback value.
- A3  out  5  writeback register.
- WE  out  1  writeback strobe.
- ERR  out  1  misalign/timeout flag, sticky until next accepted START.

## Operation
- States: IDLE, ACCESS, WRITE.
- IDLE + START: latch OP, FUNCT3, RD, ALU_Y, PC, STORE_DATA; clear ERR; BUSY=1.
  - OP 00 → WRITE with WB=ALU_Y. OP 11 → WRITE with WB=PC+4 (32-bit, wraps modulo 2^32).
  - OP 01/10, misaligned (half with addr[0]=1, word with addr[1:0]≠0) → ERR=1, back to IDLE, no MEM_REQ, no WE.
  - OP 01/10, aligned → ACCESS.
- ACCESS: MEM_REQ=1; MEM_ADDR/MEM_BE/MEM_WR/MEM_WDATA stable until ACK.
  - BE: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - WDATA: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
  - ACK on store → IDLE. ACK on load → capture lane, extend (sign for 000/001, zero for 100/101), WB=result, → WRITE.
- WRITE: WE=1 for one cycle with A3=RD unless RD=0 (WE stays 0); → IDLE.
- START while BUSY is ignored. MEM_ACK outside ACCESS is ignored.
- Undefined FUNCT3 on load/store is treated as word.

## Timing
- All outputs are registered; reset value 0 for every output, state=IDLE.
- START sampled at edge 0:
  - ALU/jump: WE high in cycle 1, BUSY low in cycle 2.
  - Load/store: MEM_REQ high from cycle 1. If ACK is sampled at edge k, MEM_REQ is low in cycle k+1.
  - Load: WE high in cycle k+1.
  - Misalign: ERR high from cycle 1, BUSY low in cycle 1.
- Minimum throughput: one instruction per 2 cycles (ALU); load ≥3 cycles.
- RST asserted at any point forces MEM_REQ, WE, BUSY and ERR to 0 immediately and aborts the transaction. A late MEM_ACK after reset is ignored.

## Configuration
- MEM_TIMEOUT_EN defined: an 8+ bit counter runs in ACCESS. After TIMEOUT_CYCLES cycles without ACK: drop MEM_REQ, ERR=1, no WE, → IDLE.
- MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely. No counter is present, and ERR reports misalignment only.

## Test plan
- ALU op: OP=00, RD=5, ALU_Y=0x12345678 → WE=1 for exactly one cycle, A3=5, WB=0x12345678.
- Signed byte load: OP=01, FUNCT3=000, ALU_Y=0x103, ACK after 3 cycles with RDATA=0x80FFFFFF → MEM_ADDR=0x100, BE=1000, WB=0xFFFFFF80. Repeat with FUNCT3=100 → WB=0x00000080.
- Half store: OP=10, FUNCT3=001, ALU_Y=0x202, STORE_DATA=0xAAAABEEF → BE=1100, WDATA=0xBEEFBEEF, MEM_WR=1, no WE.
- Misaligned word load at 0x101 → ERR=1, MEM_REQ never asserted, WE=0. Next START clears ERR.
- RD=0 jump-link with PC=0xFFFFFFFC → WE stays 0 (WB=0x00000000). RST pulsed during ACCESS → MEM_REQ=0 next cycle and a subsequent ACK is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK → MEM_REQ drops after 4 cycles, ERR=1, WE=0.
